fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline latch of the 5-stage MIPS pipeline.
//  Owns the PC and drives the instruction-memory read request.
//  Latches fetched instructions into IF/ID under control of the hazard unit (h_pcen, ifid_pause), the memory-stage stall and branch/jump redirects.
//  A one-entry hold buffer keeps an instruction that returned while the pipe was frozen, so it is not refetched.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
//  NOP_WORD  32'h0000_0000  instruction word inserted into IF/ID as a bubble (sll $0,$0,0)
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  RST          in   1   synchronous reset, active-high
//  ihit         in   1   instruction memory returned imemload for imemaddr this cycle
//  imemload     in   32  instruction word from memory, valid when ihit
//  h_pcen       in   1   hazard unit: PC may advance
//  ifid_pause   in   1   hazard unit: hold IF/ID contents
//  dmem_stall   in   1   MEM stage waiting on dhit; entire front end frozen
//  redirect_en  in   1   taken branch/jump resolved downstream this cycle
//  redirect_pc  in   32  target PC for redirect_en
//  halt         in   1   HALT reached MEM stage; stop fetching
//  imemREN      out  1   instruction read request
//  imemaddr     out  32  instruction address (= PC)
//  ifid_instr   out  32  IF/ID latched instruction
//  ifid_npc     out  32  IF/ID latched PC+4 of that instruction
//  ifid_valid   out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - Reset (RST=1 at edge, overrides all): PC=PC_INIT, state=FETCH, buffer empty, ifid_instr=NOP_WORD, ifid_npc=0, ifid_valid=0. Combinational outputs follow: imemREN=1, imemaddr=PC_INIT.
//  - advance = h_pcen & ~ifid_pause & ~dmem_stall. When advance=0, IF/ID holds and PC holds.
//  - imemaddr = PC always. imemREN = 1 only in FETCH.
//  - FSM states FETCH, HELD, HALTED (enum fetch_state_t):
//    FETCH, ihit & advance: IF/ID <= {imemload, PC+4, valid=1}; PC <= PC+4; stay in FETCH.
//    FETCH, ihit & ~advance: buffer <= imemload; go to HELD (IF/ID, PC unchanged).
//    FETCH, ~ihit & advance: IF/ID <= bubble (NOP_WORD, valid=0); PC unchanged.
//    HELD, advance: IF/ID <= {buffer, PC+4, 1}; PC <= PC+4; go to FETCH. imemREN=0 while in HELD.
//    HALTED: imemREN=0; IF/ID loads bubble on advance; exit only through reset.
//  - Redirect: sampled only when dmem_stall=0. It takes priority over all of the above (except reset and halt). Effect: PC <= redirect_pc; IF/ID <= bubble; buffer dropped; state <= FETCH. A coincident ihit is discarded. A redirect overrides ifid_pause and h_pcen.
//  - halt=1 (dmem_stall=0): state <= HALTED; IF/ID <= bubble; halt has priority over redirect.
//  - Latency: an instruction enters IF/ID on the edge of its ihit cycle if advance=1; otherwise on the first later edge with advance=1.
//  - Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 without error. PC[1:0] is forced 00 on every load, including redirect.
//  - Memory-side abort: a fetch in flight when a redirect occurs is abandoned. The next cycle issues imemaddr=redirect_pc. Memory is expected to tolerate an address change while REN is held.
// STRUCTURE
//  - cpu_types_pkg gets word_t (32b), the fetch_state_t enum and the constants PC_INIT_DEFAULT and NOP_WORD.
//  - The hazard-unit signals arrive through hazard_unit_if (hu-side outputs h_pcen, ifid_pause).
//  - No sub-module: the PC register, hold buffer, FSM and IF/ID latch are one always_ff block with one always_comb next-state block.
// TESTING
//  1 Reset then ihit=1 every cycle, no stalls: imemaddr 0,4,8,... Each instruction appears in IF/ID one edge later with npc=addr+4 and valid=1.
//  2 ihit at PC=8 with ifid_pause=1 for 3 cycles: state=HELD, imemREN=0, IF/ID unchanged. On release, IF/ID=instr@8 and npc=12, with no second read of 8.
//  3 redirect_en=1, redirect_pc=0x40, ihit=1 in the same cycle: the imemload is dropped, IF/ID=bubble and the next imemaddr=0x40.
//  4 redirect_en=1 while dmem_stall=1: ignored and PC unchanged. Re-asserted after the stall clears: PC=target.
//  5 halt=1: imemREN=0 from the next cycle. Further ihit, redirects and stalls have no effect until RST=1, after which PC=PC_INIT.
//  6 PC forced to 0xFFFF_FFFC via redirect, then ihit with advance: ifid_npc=0 and PC=0. RST asserted mid-HELD: buffer cleared and state=FETCH.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM encoding and front-end reset constants.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HELD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
    // sll $0,$0,0
    localparam word_t NOP_WORD        = 32'h0000_0000;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit to fetch-stage control bundle.
interface hazard_unit_if;
    logic h_pcen;
    logic ifid_pause;

    modport hu    (output h_pcen, output ifid_pause);
    modport fetch (input h_pcen, input ifid_pause);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID latch: PC register, one-entry hold buffer, fetch FSM.
// Handshake: an instruction is accepted when ihit=1; it moves into IF/ID only on an edge with advance=1.
module fetch_stage #(
    parameter cpu_types_pkg::word_t PC_INIT  = cpu_types_pkg::PC_INIT_DEFAULT,
    parameter cpu_types_pkg::word_t NOP_WORD = cpu_types_pkg::NOP_WORD
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ihit,
    input  logic [31:0]                 imemload,
    hazard_unit_if.fetch                hu,
    input  logic                        dmem_stall,
    input  logic                        redirect_en,
    input  logic [31:0]                 redirect_pc,
    input  logic                        halt,
    output logic                        imemREN,
    output logic [31:0]                 imemaddr,
    output logic [31:0]                 ifid_instr,
    output logic [31:0]                 ifid_npc,
    output logic                        ifid_valid,
    output cpu_types_pkg::fetch_state_t state_dbg
);
    import cpu_types_pkg::*;

    fetch_state_t state, state_n;
    word_t        pc, pc_n, pc_plus4;
    word_t        buffer, buffer_n;
    word_t        instr_n, npc_n;
    logic         valid_n;
    logic         advance;

    assign advance  = hu.h_pcen & ~hu.ifid_pause & ~dmem_stall;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= {PC_INIT[31:2], 2'b00};
            buffer     <= '0;
            ifid_instr <= NOP_WORD;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= {pc_n[31:2], 2'b00};
            buffer     <= buffer_n;
            ifid_instr <= instr_n;
            ifid_npc   <= npc_n;
            ifid_valid <= valid_n;
        end
    end

    // Priority: halt > sticky HALTED > redirect > normal fetch; a stalled MEM stage masks halt/redirect.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        buffer_n = buffer;
        instr_n  = ifid_instr;
        npc_n    = ifid_npc;
        valid_n  = ifid_valid;
        if (!dmem_stall && halt) begin
            state_n = HALTED;
            instr_n = NOP_WORD;
            npc_n   = '0;
            valid_n = 1'b0;
        end else if (state == HALTED) begin
            if (advance) begin
                instr_n = NOP_WORD;
                npc_n   = '0;
                valid_n = 1'b0;
            end
        end else if (!dmem_stall && redirect_en) begin
            state_n  = FETCH;
            pc_n     = redirect_pc;
            buffer_n = '0;
            instr_n  = NOP_WORD;
            npc_n    = '0;
            valid_n  = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit && advance) begin
                        instr_n = imemload;
                        npc_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end else if (ihit) begin
                        buffer_n = imemload;
                        state_n  = HELD;
                    end else if (advance) begin
                        instr_n = NOP_WORD;
                        npc_n   = '0;
                        valid_n = 1'b0;
                    end
                end
                HELD: begin
                    if (advance) begin
                        instr_n = buffer;
                        npc_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_comb begin
        imemREN   = (state == FETCH);
        imemaddr  = pc;
        state_dbg = state;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: driver pushes expected post-edge state, negedge monitor compares.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam int W = 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        dmem_stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    fetch_state_t state_dbg;

    hazard_unit_if hu_if ();

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    fetch_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .hu          (hu_if),
        .dmem_stall  (dmem_stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, queue the state expected after the edge.
    task automatic cycle(input logic rst, input logic hit, input logic [31:0] load,
                         input logic pcen, input logic pause, input logic dstall,
                         input logic redir, input logic [31:0] rpc, input logic hlt,
                         input logic [31:0] e_instr, input logic [31:0] e_npc, input logic e_valid,
                         input logic [31:0] e_addr, input logic e_ren, input fetch_state_t e_state);
        RST              = rst;
        ihit             = hit;
        imemload         = load;
        hu_if.h_pcen     = pcen;
        hu_if.ifid_pause = pause;
        dmem_stall       = dstall;
        redirect_en      = redir;
        redirect_pc      = rpc;
        halt             = hlt;
        exp_q.push_back({e_instr, e_npc, e_valid, e_addr, e_ren, e_state});
        @(posedge CLK);
        #2;
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("ifid_instr", ifid_instr, e[99:68]);
                if (e[35]) cmp("ifid_npc", ifid_npc, e[67:36]);
                cmp("ifid_valid", {31'b0, ifid_valid}, {31'b0, e[35]});
                cmp("imemaddr", imemaddr, e[34:3]);
                cmp("imemREN", {31'b0, imemREN}, {31'b0, e[2]});
                cmp("state", {30'b0, state_dbg}, {30'b0, e[1:0]});
            end
        end
    end

    initial begin
        hu_if.h_pcen     = 1'b1;
        hu_if.ifid_pause = 1'b0;

        // reset and straight-line fetch
        cycle(1, 0, 0,            1, 0, 0, 0, 0, 0,  NOP_WORD,     0,     0, 32'h0,  1, FETCH);
        cycle(0, 1, 32'hA000_0000, 1, 0, 0, 0, 0, 0, 32'hA000_0000, 32'h4, 1, 32'h4,  1, FETCH);
        cycle(0, 1, 32'hA000_0004, 1, 0, 0, 0, 0, 0, 32'hA000_0004, 32'h8, 1, 32'h8,  1, FETCH);
        // ihit at 8 under pause: held three cycles, released without refetch
        cycle(0, 1, 32'hA000_0008, 1, 1, 0, 0, 0, 0, 32'hA000_0004, 32'h8, 1, 32'h8,  0, HELD);
        cycle(0, 0, 0,            1, 1, 0, 0, 0, 0, 32'hA000_0004, 32'h8, 1, 32'h8,  0, HELD);
        cycle(0, 0, 0,            1, 1, 0, 0, 0, 0, 32'hA000_0004, 32'h8, 1, 32'h8,  0, HELD);
        cycle(0, 0, 0,            1, 0, 0, 0, 0, 0, 32'hA000_0008, 32'hC, 1, 32'hC,  1, FETCH);
        // miss with advance inserts a bubble
        cycle(0, 0, 0,            1, 0, 0, 0, 0, 0, NOP_WORD,     0,     0, 32'hC,  1, FETCH);
        // redirect with coincident ihit drops the word
        cycle(0, 1, 32'hA000_000C, 1, 0, 0, 1, 32'h40, 0, NOP_WORD, 0,   0, 32'h40, 1, FETCH);
        cycle(0, 1, 32'hA000_0040, 1, 0, 0, 0, 0, 0, 32'hA000_0040, 32'h44, 1, 32'h44, 1, FETCH);
        // redirect beats pause and pcen=0; low PC bits cleared
        cycle(0, 0, 0,            0, 1, 0, 1, 32'h83, 0, NOP_WORD,  0,   0, 32'h80, 1, FETCH);
        cycle(0, 1, 32'hA000_0080, 1, 0, 0, 0, 0, 0, 32'hA000_0080, 32'h84, 1, 32'h84, 1, FETCH);
        // redirect under dmem_stall ignored, honoured once stall clears
        cycle(0, 0, 0,            1, 0, 1, 1, 32'h100, 0, 32'hA000_0080, 32'h84, 1, 32'h84, 1, FETCH);
        cycle(0, 0, 0,            1, 0, 0, 1, 32'h100, 0, NOP_WORD,  0,   0, 32'h100, 1, FETCH);
        // ihit under dmem_stall: held; redirect while stalled ignored
        cycle(0, 1, 32'hA000_0100, 1, 0, 1, 0, 0, 0, NOP_WORD,     0,     0, 32'h100, 0, HELD);
        cycle(0, 0, 0,            1, 0, 1, 1, 32'h300, 0, NOP_WORD, 0,   0, 32'h100, 0, HELD);
        cycle(0, 0, 0,            1, 0, 0, 0, 0, 0, 32'hA000_0100, 32'h104, 1, 32'h104, 1, FETCH);
        // redirect while HELD discards the buffered word
        cycle(0, 1, 32'hA000_0104, 1, 1, 0, 0, 0, 0, 32'hA000_0100, 32'h104, 1, 32'h104, 0, HELD);
        cycle(0, 0, 0,            1, 1, 0, 1, 32'h200, 0, NOP_WORD,  0,   0, 32'h200, 1, FETCH);
        cycle(0, 0, 0,            1, 0, 0, 0, 0, 0, NOP_WORD,     0,     0, 32'h200, 1, FETCH);
        // halt (beats a coincident redirect); sticky until reset
        cycle(0, 1, 32'hA000_0200, 1, 0, 0, 1, 32'h300, 1, NOP_WORD, 0,  0, 32'h200, 0, HALTED);
        cycle(0, 1, 32'hA000_0204, 1, 0, 0, 1, 32'h300, 0, NOP_WORD, 0,  0, 32'h200, 0, HALTED);
        cycle(0, 1, 32'hA000_0208, 1, 1, 1, 0, 0, 0, NOP_WORD,     0,     0, 32'h200, 0, HALTED);
        cycle(1, 0, 0,            1, 0, 0, 0, 0, 0, NOP_WORD,     0,     0, 32'h0,   1, FETCH);
        // PC wrap at 0xFFFF_FFFC
        cycle(0, 0, 0,            1, 0, 0, 1, 32'hFFFF_FFFC, 0, NOP_WORD, 0, 0, 32'hFFFF_FFFC, 1, FETCH);
        cycle(0, 1, 32'hA000_00FC, 1, 0, 0, 0, 0, 0, 32'hA000_00FC, 32'h0, 1, 32'h0, 1, FETCH);
        // reset while HELD clears buffer and state
        cycle(0, 1, 32'hA111_1111, 1, 1, 0, 0, 0, 0, 32'hA000_00FC, 32'h0, 1, 32'h0, 0, HELD);
        cycle(1, 0, 0,            1, 0, 0, 0, 0, 0, NOP_WORD,     0,     0, 32'h0,   1, FETCH);
        cycle(0, 0, 0,            1, 0, 0, 0, 0, 0, NOP_WORD,     0,     0, 32'h0,   1, FETCH);
        cycle(0, 1, 32'hA222_2222, 1, 0, 0, 0, 0, 0, 32'hA222_2222, 32'h4, 1, 32'h4, 1, FETCH);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
